// File: rtl/uart_loader_pkg.sv
// Shared constants and FSM state type for the UART memory loader.
package uart_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_LO = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_LEN     = 3'd3,
    ST_DATA    = 3'd4,
    ST_CHK     = 3'd5,
    ST_RESP    = 3'd6
  } loader_state_t;

endpackage

// File: rtl/uart_byte_packer.sv
// Byte-to-word assembler: little-endian packing, registered word output
// with a one-cycle valid pulse after the word's last byte is taken.
module uart_byte_packer #(
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_last_c,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_word_valid
);

  localparam int unsigned WW = 8 * WORD_BYTES;
  localparam int unsigned CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_acc;
  logic [WW-1:0] r_word;
  logic          r_word_valid;
  logic [WW-1:0] w_acc_next;

  assign o_last_c     = (r_cnt == CW'(WORD_BYTES - 1));
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

  // Drop the incoming byte into its lane selected by the byte counter.
  always_comb begin
    w_acc_next = r_acc;
    for (int b = 0; b < int'(WORD_BYTES); b++) begin
      if (r_cnt == CW'(b)) begin
        w_acc_next[b*8 +: 8] = i_byte;
      end
    end
  end

  // Byte counter, accumulator and registered word/valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_byte_valid) begin
        if (o_last_c) begin
          r_cnt        <= '0;
          r_word       <= w_acc_next;
          r_word_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= w_acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial frame parser that writes little-endian words into a data memory
// and answers each frame with one ACK/NAK byte.
// Optional feature macro: UART_LOADER_CHKSUM_EN (XOR checksum byte verified).
module uart_mem_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    busy,
  output logic                    load_done,
  output logic                    frame_error
);

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic                  r_rx_ready;
  logic                  r_tx_valid;
  logic [7:0]            r_tx_data;
  logic [7:0]            w_tx_data;
  logic                  w_resp_ack;
  logic                  r_busy;
  logic [7:0]            r_addr_lo;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [7:0]            r_len;
  logic [7:0]            r_word_idx;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  w_accept;
  logic                  w_tx_hs;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_pack_valid;

`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0]            r_chk;
`endif

  assign w_accept    = rx_valid && r_rx_ready;
  assign w_tx_hs     = r_tx_valid && tx_ready;
  assign w_last_word = (r_word_idx == (r_len - 8'd1));

  assign rx_ready    = r_rx_ready;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign mem_addr    = r_mem_addr;
  assign load_done   = w_tx_hs && (r_tx_data == ACK_BYTE);
  assign frame_error = w_tx_hs && (r_tx_data == NAK_BYTE);

  assign w_pack_valid = w_accept && (r_state == ST_DATA);

  // Word assembly; its registered strobe/data drive the memory port directly.
  uart_byte_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (r_state == ST_IDLE),
    .i_byte_valid (w_pack_valid),
    .i_byte       (rx_data),
    .o_last_c     (w_last_byte),
    .o_word       (mem_wdata),
    .o_word_valid (mem_we)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and response byte selection.
  always_comb begin
    w_next_state = r_state;
    w_resp_ack   = 1'b0;
    w_tx_data    = r_tx_data;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (rx_data == SYNC_BYTE)) w_next_state = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        if (w_accept) w_next_state = ST_ADDR_HI;
      end
      ST_ADDR_HI: begin
        if (w_accept) w_next_state = ST_LEN;
      end
      ST_LEN: begin
        if (w_accept) begin
          if (rx_data == 8'h00) begin
            w_next_state = ST_RESP;
            w_resp_ack   = 1'b0;
          end else begin
            w_next_state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept && w_last_byte && w_last_word) begin
`ifdef UART_LOADER_CHKSUM_EN
          w_next_state = ST_CHK;
`else
          w_next_state = ST_RESP;
          w_resp_ack   = 1'b1;
`endif
        end
      end
`ifdef UART_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (w_accept) begin
          w_next_state = ST_RESP;
          w_resp_ack   = (rx_data == r_chk);
        end
      end
`endif
      ST_RESP: begin
        if (w_tx_hs) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if ((w_next_state == ST_RESP) && (r_state != ST_RESP)) begin
      w_tx_data = w_resp_ack ? ACK_BYTE : NAK_BYTE;
    end
  end

  // Registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_ready <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_rx_ready <= (w_next_state != ST_RESP);
      r_tx_valid <= (w_next_state == ST_RESP);
      r_tx_data  <= w_tx_data;
      r_busy     <= (w_next_state != ST_IDLE);
    end
  end

  // Frame header capture, word counter and write address generation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_lo  <= 8'h00;
      r_start    <= '0;
      r_len      <= 8'h00;
      r_word_idx <= 8'h00;
      r_mem_addr <= '0;
    end else if (w_accept) begin
      case (r_state)
        ST_ADDR_LO: r_addr_lo <= rx_data;
        ST_ADDR_HI: r_start   <= ADDR_WIDTH'({rx_data, r_addr_lo});
        ST_LEN: begin
          r_len      <= rx_data;
          r_word_idx <= 8'h00;
        end
        ST_DATA: begin
          if (w_last_byte) begin
            r_mem_addr <= r_start + ADDR_WIDTH'(r_word_idx);
            r_word_idx <= r_word_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_LOADER_CHKSUM_EN
  // Running XOR over address, length and data bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk <= 8'h00;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE:    r_chk <= 8'h00;
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_LEN,
        ST_DATA:    r_chk <= r_chk ^ rx_data;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader; honours UART_LOADER_CHKSUM_EN.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        load_done;
  logic        frame_error;

  int n_cmp = 0;
  int n_mis = 0;

  int wr_cnt = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int we_high_run = 0;
  logic [7:0] tx_last = 8'h00;
  logic [9:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  fr[$];

  int wr0, tx0, dn0, er0;

  uart_mem_loader #(
    .DATA_WIDTH (8),
    .WORD_BYTES (4),
    .ADDR_WIDTH (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .load_done   (load_done),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Observe writes, responses and status pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      we_high_run++;
    end else begin
      we_high_run = 0;
    end
    if (tx_valid && tx_ready) begin
      tx_cnt++;
      tx_last = tx_data;
    end
    if (load_done) done_cnt++;
    if (frame_error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fr[i]) send_byte(fr[i]);
  endtask

  task automatic snap();
    wr0 = wr_cnt;
    tx0 = tx_cnt;
    dn0 = done_cnt;
    er0 = err_cnt;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata,    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single-word frame with good checksum
    snap();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_LOADER_CHKSUM_EN
    fr.push_back(8'h55);
`endif
    send_frame();
    settle();
    check("f1_writes", 32'(wr_cnt - wr0), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check("f1_addr", 32'(wr_addr_q[0]), 32'h010);
      check("f1_data", wr_data_q[0], 32'h44332211);
    end
    check("f1_tx_count", 32'(tx_cnt - tx0), 32'd1);
    check("f1_tx_byte", 32'(tx_last), 32'h06);
    check("f1_load_done", 32'(done_cnt - dn0), 32'd1);
    check("f1_frame_err", 32'(err_cnt - er0), 32'd0);
    check("f1_idle_busy", 32'(busy), 32'd0);

`ifdef UART_LOADER_CHKSUM_EN
    // Same frame, bad checksum: write kept, NAK returned
    snap();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_frame();
    settle();
    check("bad_chk_writes", 32'(wr_cnt - wr0), 32'd1);
    check("bad_chk_tx_byte", 32'(tx_last), 32'h15);
    check("bad_chk_frame_err", 32'(err_cnt - er0), 32'd1);
    check("bad_chk_load_done", 32'(done_cnt - dn0), 32'd0);
`endif

    // Two words starting at the top address: wraps to 0
    snap();
    fr = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04,
           8'h05, 8'h06, 8'h07, 8'h08};
`ifdef UART_LOADER_CHKSUM_EN
    fr.push_back(8'hF6);
`endif
    send_frame();
    settle();
    check("wrap_writes", 32'(wr_cnt - wr0), 32'd2);
    if (wr_addr_q.size() > 1) begin
      check("wrap_addr0", 32'(wr_addr_q[0]), 32'h3FF);
      check("wrap_data0", wr_data_q[0], 32'h04030201);
      check("wrap_addr1", 32'(wr_addr_q[1]), 32'h000);
      check("wrap_data1", wr_data_q[1], 32'h08070605);
    end
    check("wrap_tx_byte", 32'(tx_last), 32'h06);
    check("wrap_we_single", 32'(we_high_run), 32'd0);

    // Junk bytes before SYNC are dropped
    snap();
    fr = '{8'h00, 8'h7E, 8'hA5, 8'h34, 8'h01, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef UART_LOADER_CHKSUM_EN
    fr.push_back(8'h34);
`endif
    send_frame();
    settle();
    check("junk_writes", 32'(wr_cnt - wr0), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check("junk_addr", 32'(wr_addr_q[0]), 32'h134);
      check("junk_data", wr_data_q[0], 32'hDDCCBBAA);
    end
    check("junk_tx_count", 32'(tx_cnt - tx0), 32'd1);
    check("junk_tx_byte", 32'(tx_last), 32'h06);

    // LEN=0 gives NAK; response held while tx_ready is low
    snap();
    tx_ready = 1'b0;
    fr = '{8'hA5, 8'h20, 8'h00, 8'h00};
    send_frame();
    @(negedge clk);
    check("len0_tx_valid_rise", 32'(tx_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      if (!tx_valid || tx_data !== 8'h15 || rx_ready) begin
        check("len0_hold_tx_valid", 32'(tx_valid), 32'd1);
        check("len0_hold_tx_data", 32'(tx_data), 32'h15);
        check("len0_hold_rx_ready", 32'(rx_ready), 32'd0);
      end
      @(negedge clk);
    end
    check("len0_held_tx_data", 32'(tx_data), 32'h15);
    check("len0_held_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    settle();
    check("len0_writes", 32'(wr_cnt - wr0), 32'd0);
    check("len0_tx_count", 32'(tx_cnt - tx0), 32'd1);
    check("len0_tx_byte", 32'(tx_last), 32'h15);
    check("len0_frame_err", 32'(err_cnt - er0), 32'd1);
    check("len0_load_done", 32'(done_cnt - dn0), 32'd0);

    // Reset mid-frame: partial word dropped, then a clean frame works
    snap();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h11, 8'h22};
    send_frame();
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    check("mid_rst_writes", 32'(wr_cnt - wr0), 32'd0);
    check("mid_rst_tx", 32'(tx_cnt - tx0), 32'd0);
    check("mid_rst_rx_ready_back", 32'(rx_ready), 32'd1);
    snap();
    fr = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_LOADER_CHKSUM_EN
    fr.push_back(8'h55);
`endif
    send_frame();
    settle();
    check("after_rst_writes", 32'(wr_cnt - wr0), 32'd1);
    if (wr_data_q.size() > 0) begin
      check("after_rst_data", wr_data_q[0], 32'h44332211);
    end
    check("after_rst_tx_byte", 32'(tx_last), 32'h06);
    check("after_rst_load_done", 32'(done_cnt - dn0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
# uart_mem_loader

Frame parser sitting directly downstream of the `uart` block's receive side and upstream of its transmit side. It consumes received bytes over the rx valid/ready handshake and assembles them into little-endian words. Each word is written into a synchronous data-memory port. One ACK/NAK byte is returned to the host through the tx handshake. The block loads program data and RSA operands into the pipeline CPU's memory over the serial link.

## Interface
- `DATA_WIDTH`, 8: UART byte width; only 8 is supported.
- `WORD_BYTES`, 4: bytes per memory word, 1..4.
- `ADDR_WIDTH`, 10: memory word-address width, ≤16.
- `clk` input 1: single clock; every register is clocked on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input DATA_WIDTH: received byte from `uart`.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: the loader accepts a byte.
- `tx_data` output DATA_WIDTH: response byte sent to `uart`.
- `tx_valid` output 1: response is pending.
- `tx_ready` input 1: `uart` accepts the response.
- `mem_we` output 1: one-cycle write strobe.
- `mem_addr` output ADDR_WIDTH: word address.
- `mem_wdata` output 8*WORD_BYTES: word data.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `load_done` output 1: one-cycle pulse on ACK handshake.
- `frame_error` output 1: one-cycle pulse on NAK handshake.

## Operation
- Frame layout: SYNC (0xA5), ADDR_LO, ADDR_HI, LEN, LEN×WORD_BYTES data bytes (LSB first), CHK.
- A byte is accepted on an edge where `rx_valid && rx_ready`.
- FSM states: IDLE → ADDR_LO → ADDR_HI → LEN → DATA → CHK → RESP → IDLE.
- IDLE: non-SYNC bytes are accepted and silently discarded.
- ADDR bytes: the start address is {ADDR_HI,ADDR_LO}[ADDR_WIDTH-1:0].
- LEN = 0: go directly to RESP with NAK; no writes.
- DATA: a byte counter (0..WORD_BYTES-1) and a word counter (0..LEN-1) track progress.
- Each completed word is written at start+index. The address wraps modulo 2^ADDR_WIDTH.
- Checksum: 8-bit XOR of ADDR_LO, ADDR_HI, LEN and all data bytes. CHK equal to this value → ACK (0x06); otherwise NAK (0x15).
- Words already written are not rolled back on NAK; the host resends the frame.
- RESP: `rx_ready` is 0. `tx_valid` is held with `tx_data` stable until `tx_ready`, then the FSM returns to IDLE.
- In all other states `rx_ready` = 1.

## Timing
- Reset values: `rx_ready` 0 during reset and 1 from the first cycle after reset. `tx_valid`, `mem_we`, `busy`, `load_done`, `frame_error` are 0. `tx_data`, `mem_addr`, `mem_wdata` are 0. State is IDLE.
- `mem_we` is high for exactly one cycle, the cycle after the accepting edge of a word's last byte. `mem_addr`/`mem_wdata` are valid in that same cycle.
- `tx_valid` rises the cycle after the CHK byte is accepted (or after the LEN byte, for LEN = 0).
- `load_done`/`frame_error` pulse in the cycle of the tx handshake.
- Back-to-back bytes, one per cycle, are sustained with no bubbles.
- Reset asserted mid-frame: immediate return to IDLE. The partial word is discarded, no write occurs and no response is sent.

## Configuration
- `UART_LOADER_CHKSUM_EN` defined: CHK is expected and verified as above.
- Macro undefined: there is no CHK state. DATA → RESP with ACK after the last data byte, and the checksum register is removed. LEN = 0 still gives NAK.

## Structure
- Package `uart_loader_pkg` holds: SYNC_BYTE 8'hA5, ACK_BYTE 8'h06, NAK_BYTE 8'h15, and the `loader_state_t` enum.
- Sub-module `uart_byte_packer`: a byte-to-word shift register with byte counter, `word_valid` output and clear input.

## Test plan
- A5 10 00 01 | 11 22 33 44 | CHK=0x55 → one write at addr 0x010, data 0x44332211; ACK; `load_done` pulse.
- Same frame with CHK=0x00 → write still occurs; tx 0x15; `frame_error` pulse.
- A5 FF 03 02 + 8 bytes (ADDR_WIDTH=10) → writes at 0x3FF then 0x000 (wrap).
- Bytes 00 7E then the frame → leading bytes ignored; exactly one write.
- LEN=0 → NAK, no `mem_we`. `tx_ready` held low 20 cycles → `tx_valid`/`tx_data` stable and `rx_ready`=0 throughout.
- `rst` pulsed after the 2nd data byte → no write; then a fresh valid frame → normal ACK.
